// File: rtl/uart_rx_if.sv
// Receive-side handshake between uart_rx (master) and the UART register block (slave).
// The parity_err flag exists only when UART_RX_PARITY_EN is defined.
//
// Handshake: rx_valid rises in the cycle rx_data is loaded and stays high until
// the consumer pulses rx_ack for one cycle. rx_data does not change while
// rx_valid is high, except when a new byte completes in the same cycle as rx_ack.
// In that case the new byte replaces the old one and rx_valid stays high.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       err_clr;
  logic       overrun;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;

  modport master (
    output rx_data, rx_valid, overrun, frame_err, parity_err,
    input  rx_ack, err_clr
  );
  modport slave (
    input  rx_data, rx_valid, overrun, frame_err, parity_err,
    output rx_ack, err_clr
  );
`else
  modport master (
    output rx_data, rx_valid, overrun, frame_err,
    input  rx_ack, err_clr
  );
  modport slave (
    input  rx_data, rx_valid, overrun, frame_err,
    output rx_ack, err_clr
  );
`endif
endinterface

// File: rtl/uart_rx.sv
// UART receive engine. It synchronises rxd, detects start bits and samples
// 8N1 frames (LSB first) at mid-bit using a run-time divisor. Each byte is
// handed to the register block over uart_rx_if. Overrun and framing errors are
// reported as sticky flags.
// Optional feature macro: UART_RX_PARITY_EN. It adds a parity bit between the
// data bits and the stop bit, the parity_odd input and the parity_err flag.
module uart_rx #(
  parameter int unsigned clock_freq = 100000000,
  parameter int unsigned baud_rate  = 115200,
  parameter int unsigned min_div    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        rx_en,
  input  logic [31:0] baud_div,
`ifdef UART_RX_PARITY_EN
  input  logic        parity_odd,
`endif
  output logic        busy,
  output logic [4:0]  state_dbg,
  uart_rx_if.master   bus
);

  localparam logic [31:0] DefDiv = 32'(clock_freq / baud_rate);
  localparam logic [31:0] MinDiv = 32'(min_div);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        prev_q, prev_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] div_q, div_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        done_q, done_d;
  logic        stop_ok_q, stop_ok_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic        par_bad_q, par_bad_d;
  logic        parity_err_q, parity_err_d;
`endif

  logic [31:0] div_sel;
  logic        start_edge;

  // Two-flop synchroniser plus a delay flop used for falling-edge detection.
  always_comb begin
    sync1_d    = rxd;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    start_edge = prev_q & ~sync2_q;
  end

  // Effective divisor. Zero selects the build-time default and small values are clamped.
  always_comb begin
    div_sel = baud_div;
    if (baud_div == 32'd0) begin
      div_sel = DefDiv;
    end else if (baud_div < MinDiv) begin
      div_sel = MinDiv;
    end
  end

  // Frame FSM: next state, bit counter, shift register and completion pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    stop_ok_d = stop_ok_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_edge && rx_en) begin
          state_d = START;
          div_d   = div_sel;
          cnt_d   = (div_sel >> 1) - 32'd1;
        end
      end
      START: begin
        if (cnt_q == 32'd0) begin
          if (sync2_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            cnt_d     = div_q - 32'd1;
            bit_idx_d = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      DATA: begin
        if (cnt_q == 32'd0) begin
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = div_q - 32'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == 32'd0) begin
          // The expected parity bit makes the count of ones even, or odd when parity_odd is set.
          par_bad_d = sync2_q ^ (^shift_q) ^ parity_odd;
          cnt_d     = div_q - 32'd1;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == 32'd0) begin
          stop_ok_d = sync2_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Dropping the enable abandons the frame in progress without touching the flags.
    if (state_q != IDLE && !rx_en) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
  end

  // Output side: byte delivery, acknowledge and sticky error flags (a new error wins over err_clr).
  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (bus.err_clr) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end
    if (bus.rx_ack) begin
      rx_valid_d = 1'b0;
    end
    if (done_q) begin
      if (!rx_valid_q || bus.rx_ack) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
      if (!stop_ok_q) begin
        frame_err_d = 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      if (par_bad_q) begin
        parity_err_d = 1'b1;
      end
`endif
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      cnt_q       <= 32'd0;
      div_q       <= 32'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      done_q      <= 1'b0;
      stop_ok_q   <= 1'b0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      stop_ok_q   <= stop_ok_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`endif
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. A frame-level model predicts rx_valid,
// rx_data and the sticky flags every cycle, and directed checks pin literal values.
module tb_uart_rx;
  logic        clk = 1'b0;
  logic        rst;
  logic        rxd;
  logic        rx_en;
  logic [31:0] baud_div;
  logic        busy;
  logic [4:0]  state_dbg;
`ifdef UART_RX_PARITY_EN
  logic        parity_odd;
`endif

  uart_rx_if bus();

  uart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_en     (rx_en),
    .baud_div  (baud_div),
`ifdef UART_RX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .busy      (busy),
    .state_dbg (state_dbg),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;
  int n_prints = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int chg_at = -1;
  logic [31:0] chg_val = 32'd0;
  int first_valid_k;

  // ---------------- scoreboard / model ----------------
  int         due_q[$];
  logic [7:0] exp_q[$];
  bit         stop_q[$];
  bit         pbad_q[$];
  logic [7:0] m_data  = 8'd0;
  bit         m_valid = 1'b0;
  bit         m_ovr   = 1'b0;
  bit         m_ferr  = 1'b0;
  bit         m_perr  = 1'b0;

  // Model update: applies ack, err_clr and due frame completions at each rising edge.
  always @(posedge clk) begin
    bit v0;
    cyc++;
    if (rst !== 1'b1) begin
      m_data = 8'd0; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
      due_q.delete(); exp_q.delete(); stop_q.delete(); pbad_q.delete();
    end else begin
      v0 = m_valid;
      if (bus.err_clr) begin
        m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
      end
      if (bus.rx_ack) m_valid = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        if (!v0 || bus.rx_ack) begin
          m_data  = exp_q[0];
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
        if (!stop_q[0]) m_ferr = 1'b1;
        if (pbad_q[0]) m_perr = 1'b1;
        void'(due_q.pop_front()); void'(exp_q.pop_front());
        void'(stop_q.pop_front()); void'(pbad_q.pop_front());
      end
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    bit bad;
    if (chk_en) begin
      bad = (bus.rx_valid !== m_valid) || (bus.rx_data !== m_data) ||
            (bus.overrun !== m_ovr) || (bus.frame_err !== m_ferr);
`ifdef UART_RX_PARITY_EN
      if (bus.parity_err !== m_perr) bad = 1'b1;
`endif
      n_total++;
      if (!bad) begin
        n_pass++;
      end else if (n_prints < 20) begin
        n_prints++;
        $display("FAIL model_cycle %0d: valid %b exp %b, data %h exp %h, overrun %b exp %b, frame_err %b exp %b",
                 cyc, bus.rx_valid, m_valid, bus.rx_data, m_data, bus.overrun, m_ovr,
                 bus.frame_err, m_ferr);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks (all start and end at a falling edge) ----------------
  task automatic send_frame(input logic [7:0] data, input bit stop_bit, input bit par_flip,
                            input bit expect_done, input bit ack_on_done,
                            input int abort_at, input int reset_at);
    int div, half, nbits, n0, due, total;
    logic [10:0] bits;
    div  = (baud_div == 32'd0) ? 868 : ((baud_div < 32'd4) ? 4 : int'(baud_div));
    half = div / 2;
`ifdef UART_RX_PARITY_EN
    nbits = 10;
    bits  = {stop_bit, (^data) ^ parity_odd ^ par_flip, data, 1'b0};
`else
    nbits = 9;
    bits  = {1'b1, stop_bit, data, 1'b0};
`endif
    n0  = cyc;
    due = n0 + 4 + half + nbits * div;
    if (expect_done) begin
      due_q.push_back(due); exp_q.push_back(data);
      stop_q.push_back(stop_bit); pbad_q.push_back(par_flip);
    end
    total = (nbits + 1) * div + 8;
    first_valid_k = -1;
    for (int k = 0; k < total; k++) begin
      rxd = (k < (nbits + 1) * div) ? bits[k / div] : 1'b1;
      bus.rx_ack = ack_on_done && (cyc + 1 == due);
      if (k == chg_at) baud_div = chg_val;
      if (abort_at >= 0 && k == abort_at) begin
        check("busy_before_abort", 32'(busy), 32'd1);
        rx_en = 1'b0;
      end
      if (abort_at >= 0 && k == abort_at + 1) check("busy_after_abort", 32'(busy), 32'd0);
      if (reset_at >= 0 && k >= reset_at) rxd = 1'b1;
      if (reset_at >= 0 && k == reset_at) rst = 1'b0;
      if (reset_at >= 0 && k == reset_at + 1) begin
        rst = 1'b1;
        check("reset_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("reset_rx_data", 32'(bus.rx_data), 32'd0);
        check("reset_overrun", 32'(bus.overrun), 32'd0);
        check("reset_frame_err", 32'(bus.frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
      end
      if (bus.rx_valid === 1'b1 && first_valid_k < 0) first_valid_k = k;
      @(negedge clk);
    end
    rx_en = 1'b1;
    bus.rx_ack = 1'b0;
    chg_at = -1;
  endtask

  task automatic glitch(input int len);
    for (int k = 0; k < 20; k++) begin
      rxd = (k < len) ? 1'b0 : 1'b1;
      if (k == 4) check("glitch_busy_start", 32'(busy), 32'd1);
      if (k == 12) check("glitch_busy_idle", 32'(busy), 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic ack_pulse();
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
  endtask

  task automatic clr_pulse();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0; rxd = 1'b1; rx_en = 1'b1; baud_div = 32'd16;
    bus.rx_ack = 1'b0; bus.err_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_odd = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    chk_en = 1'b1;
    repeat (4) @(negedge clk);

    // Normal byte with latency measurement.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1);
    check("a5_latency_in_range", 32'(first_valid_k >= 155 && first_valid_k <= 157), 32'd1);
    check("a5_data", 32'(bus.rx_data), 32'hA5);
    check("a5_frame_err", 32'(bus.frame_err), 32'd0);
    check("a5_overrun", 32'(bus.overrun), 32'd0);
    ack_pulse();
    check("a5_valid_after_ack", 32'(bus.rx_valid), 32'd0);

    // Overrun: second byte arrives before the first is acknowledged.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1);
    check("ovr_data_kept", 32'(bus.rx_data), 32'h3C);
    check("ovr_flag", 32'(bus.overrun), 32'd1);
    clr_pulse();
    check("ovr_cleared", 32'(bus.overrun), 32'd0);
    ack_pulse();

    // Acknowledge coincides with completion: new byte replaces old, no overrun.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1);
    send_frame(8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1);
    check("ackdone_data", 32'(bus.rx_data), 32'hC3);
    check("ackdone_valid", 32'(bus.rx_valid), 32'd1);
    check("ackdone_overrun", 32'(bus.overrun), 32'd0);
    ack_pulse();

    // Short glitch is rejected as a false start.
    glitch(5);

    // Stop bit low: byte still delivered, framing error raised then cleared.
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
    check("ferr_data", 32'(bus.rx_data), 32'h5A);
    check("ferr_flag", 32'(bus.frame_err), 32'd1);
    ack_pulse();
    clr_pulse();
    check("ferr_cleared", 32'(bus.frame_err), 32'd0);
    repeat (4) @(negedge clk);

    // Divisor zero selects the default 868 clocks per bit.
    baud_div = 32'd0;
    send_frame(8'h55, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1);
    check("div0_data", 32'(bus.rx_data), 32'h55);
    ack_pulse();

    // Divisor below the minimum is clamped to 4.
    baud_div = 32'd2;
    send_frame(8'h0F, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1);
    check("div2_data", 32'(bus.rx_data), 32'h0F);
    ack_pulse();

    // Divisor changed in the middle of a frame has no effect on it.
    baud_div = 32'd16;
    chg_at = 48; chg_val = 32'd5;
    send_frame(8'h96, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1);
    check("midchg_data", 32'(bus.rx_data), 32'h96);
    ack_pulse();
    baud_div = 32'd16;
    repeat (4) @(negedge clk);

    // Enable dropped during bit 3: frame abandoned.
    send_frame(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 72, -1);
    check("abort_no_valid", 32'(bus.rx_valid), 32'd0);

    // Reset during DATA with a byte pending, then a clean frame.
    send_frame(8'h11, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1);
    send_frame(8'hE7, 1'b1, 1'b0, 1'b0, 1'b0, -1, 96);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1);
    check("post_reset_data", 32'(bus.rx_data), 32'h81);
    check("post_reset_valid", 32'(bus.rx_valid), 32'd1);
    ack_pulse();

`ifdef UART_RX_PARITY_EN
    // Even parity selected, parity bit deliberately wrong.
    parity_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, -1, -1);
    check("par_data", 32'(bus.rx_data), 32'h07);
    check("par_err", 32'(bus.parity_err), 32'd1);
    ack_pulse();
    clr_pulse();
    check("par_cleared", 32'(bus.parity_err), 32'd0);
`endif

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
